// File: rtl/mem_arb_pkg.sv
// Shared types for the memory refill arbiter: FSM states,
// requester IDs and the default timeout.
package mem_arb_pkg;

   localparam int TIMEOUT_CYC_DEF = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Memory-access timeout counter.
// Ports: i_clk, i_rst (sync, active-high), i_clear (hold at zero),
//        i_enable (count one waiting cycle), o_expired (this cycle
//        is the TIMEOUT_CYC-th wait cycle).
module arb_timeout_cnt
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The count reaches TIMEOUT_CYC at the edge closing this cycle.
   assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_refill_arbiter.sv
// Arbitrates I-cache and D-cache refill requests onto one memory port.
// Ports: CpuClk/CpuRst (sync, active-high); I side IReq/IAddr/IAck/IRdata;
//        D side DReq/DWe/DAddr/DWdata/DAck/DRdata; memory MemReq/MemWe/
//        MemAddr/MemWdata/MemAck/MemRdata; IMissStall/DMissStall stall
//        levels; ErrTimeout sticky timeout flag.
// Option: define MEM_ARB_ROUND_ROBIN_EN for round-robin on collisions.
module mem_refill_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int ADDR_W      = 32
) (
   input  logic              CpuClk,
   input  logic              CpuRst,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IAck,
   output logic [31:0]       IRdata,
   input  logic              DReq,
   input  logic              DWe,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [31:0]       DWdata,
   output logic              DAck,
   output logic [31:0]       DRdata,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWdata,
   input  logic              MemAck,
   input  logic [31:0]       MemRdata,
   output logic              IMissStall,
   output logic              DMissStall,
   output logic              ErrTimeout
);

   state_t            r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_iack;
   logic              r_dack;
   logic [31:0]       r_irdata;
   logic [31:0]       r_drdata;
   logic              r_err;

   logic              w_busy;
   logic              w_tmo_clr;
   logic              w_tmo_en;
   logic              w_expired;
   logic              w_pick_d;
   logic              w_any_req;
   logic [31:0]       w_cap_data;

   assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
   assign w_tmo_clr = ~w_busy;
   assign w_tmo_en  = w_busy & ~MemAck;
   assign w_any_req = IReq | DReq;

   // A timed-out access completes with zero data.
   assign w_cap_data = MemAck ? MemRdata : 32'h0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   req_id_t r_last;

   // On a collision, grant the side that did not win last time.
   assign w_pick_d = DReq & (~IReq | (r_last == REQ_I));

   always_ff @(posedge CpuClk) begin
      if (CpuRst) begin
         r_last <= REQ_I;
      end else if ((r_state == IDLE) && w_any_req) begin
         r_last <= w_pick_d ? REQ_D : REQ_I;
      end
   end
`else
   assign w_pick_d = DReq;
`endif

   arb_timeout_cnt #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_tmo (
      .i_clk    (CpuClk),
      .i_rst    (CpuRst),
      .i_clear  (w_tmo_clr),
      .i_enable (w_tmo_en),
      .o_expired(w_expired)
   );

   always_ff @(posedge CpuClk) begin
      if (CpuRst) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_iack      <= 1'b0;
         r_dack      <= 1'b0;
         r_irdata    <= '0;
         r_drdata    <= '0;
         r_err       <= 1'b0;
      end else begin
         r_iack <= 1'b0;
         r_dack <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_mem_req <= 1'b1;
                  if (w_pick_d) begin
                     r_state     <= BUSY_D;
                     r_mem_addr  <= DAddr;
                     r_mem_we    <= DWe;
                     r_mem_wdata <= DWdata;
                  end else begin
                     r_state     <= BUSY_I;
                     r_mem_addr  <= IAddr;
                     r_mem_we    <= 1'b0;
                     r_mem_wdata <= '0;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (MemAck || w_expired) begin
                  r_state   <= RESP;
                  r_mem_req <= 1'b0;
                  if (r_state == BUSY_I) begin
                     r_iack   <= 1'b1;
                     r_irdata <= w_cap_data;
                  end else begin
                     r_dack   <= 1'b1;
                     r_drdata <= w_cap_data;
                  end
                  if (!MemAck) begin
                     r_err <= 1'b1;
                  end
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign MemReq     = r_mem_req;
   assign MemWe      = r_mem_we;
   assign MemAddr    = r_mem_addr;
   assign MemWdata   = r_mem_wdata;
   assign IAck       = r_iack;
   assign DAck       = r_dack;
   assign IRdata     = r_irdata;
   assign DRdata     = r_drdata;
   assign ErrTimeout = r_err;
   assign IMissStall = IReq & ~r_iack;
   assign DMissStall = DReq & ~r_dack;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter with a transaction-level
// reference model checked every cycle.
module tb_mem_refill_arbiter;

   localparam int TO = 4;
   localparam int AW = 32;

   logic          CpuClk = 1'b0;
   logic          CpuRst = 1'b1;
   logic          IReq = 1'b0;
   logic [AW-1:0] IAddr = '0;
   logic          IAck;
   logic [31:0]   IRdata;
   logic          DReq = 1'b0;
   logic          DWe = 1'b0;
   logic [AW-1:0] DAddr = '0;
   logic [31:0]   DWdata = '0;
   logic          DAck;
   logic [31:0]   DRdata;
   logic          MemReq;
   logic          MemWe;
   logic [AW-1:0] MemAddr;
   logic [31:0]   MemWdata;
   logic          MemAck = 1'b0;
   logic [31:0]   MemRdata = '0;
   logic          IMissStall;
   logic          DMissStall;
   logic          ErrTimeout;

   always #5 CpuClk = ~CpuClk;

   mem_refill_arbiter #(
      .TIMEOUT_CYC(TO),
      .ADDR_W     (AW)
   ) dut (
      .CpuClk    (CpuClk),
      .CpuRst    (CpuRst),
      .IReq      (IReq),
      .IAddr     (IAddr),
      .IAck      (IAck),
      .IRdata    (IRdata),
      .DReq      (DReq),
      .DWe       (DWe),
      .DAddr     (DAddr),
      .DWdata    (DWdata),
      .DAck      (DAck),
      .DRdata    (DRdata),
      .MemReq    (MemReq),
      .MemWe     (MemWe),
      .MemAddr   (MemAddr),
      .MemWdata  (MemWdata),
      .MemAck    (MemAck),
      .MemRdata  (MemRdata),
      .IMissStall(IMissStall),
      .DMissStall(DMissStall),
      .ErrTimeout(ErrTimeout)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner of the memory port (0 none, 1 I, 2 D),
   // wait cycles spent so far, and the expected registered outputs.
   int          m_owner = 0;
   int          m_wait = 0;
   bit          m_last = 1'b0;
   logic        m_memreq = 1'b0;
   logic        m_memwe = 1'b0;
   logic [31:0] m_memaddr = '0;
   logic [31:0] m_memwdata = '0;
   logic        m_iack = 1'b0;
   logic        m_dack = 1'b0;
   logic [31:0] m_irdata = '0;
   logic [31:0] m_drdata = '0;
   logic        m_err = 1'b0;

   function automatic bit d_wins();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return DReq && (!IReq || !m_last);
`else
      return DReq;
`endif
   endfunction

   always @(posedge CpuClk) begin
      if (CpuRst) begin
         m_owner <= 0; m_wait <= 0; m_last <= 1'b0;
         m_memreq <= 1'b0; m_memwe <= 1'b0;
         m_memaddr <= '0; m_memwdata <= '0;
         m_iack <= 1'b0; m_dack <= 1'b0;
         m_irdata <= '0; m_drdata <= '0; m_err <= 1'b0;
      end else if (m_iack || m_dack) begin
         m_iack <= 1'b0;
         m_dack <= 1'b0;
      end else if (m_owner != 0) begin
         if (MemAck || (m_wait + 1 == TO)) begin
            m_owner  <= 0;
            m_memreq <= 1'b0;
            if (m_owner == 1) begin
               m_iack   <= 1'b1;
               m_irdata <= MemAck ? MemRdata : 32'h0;
            end else begin
               m_dack   <= 1'b1;
               m_drdata <= MemAck ? MemRdata : 32'h0;
            end
            if (!MemAck) m_err <= 1'b1;
         end else begin
            m_wait <= m_wait + 1;
         end
      end else if (IReq || DReq) begin
         m_wait   <= 0;
         m_memreq <= 1'b1;
         m_last   <= d_wins();
         if (d_wins()) begin
            m_owner    <= 2;
            m_memaddr  <= DAddr;
            m_memwe    <= DWe;
            m_memwdata <= DWdata;
         end else begin
            m_owner    <= 1;
            m_memaddr  <= IAddr;
            m_memwe    <= 1'b0;
            m_memwdata <= '0;
         end
      end
   end

   always @(negedge CpuClk) begin
      if (chk_on) begin
         chk("MemReq", MemReq, m_memreq);
         chk("MemWe", MemWe, m_memwe);
         chk("MemAddr", MemAddr, m_memaddr);
         chk("MemWdata", MemWdata, m_memwdata);
         chk("IAck", IAck, m_iack);
         chk("DAck", DAck, m_dack);
         chk("IRdata", IRdata, m_irdata);
         chk("DRdata", DRdata, m_drdata);
         chk("ErrTimeout", ErrTimeout, m_err);
         chk("IMissStall", IMissStall, IReq & ~m_iack);
         chk("DMissStall", DMissStall, DReq & ~m_dack);
      end
   end

   // Grant log: address, we and wdata seen when MemReq rises.
   logic        prev_mreq = 1'b0;
   logic [31:0] g_addr[$];
   logic        g_we[$];
   logic [31:0] g_wd[$];

   always @(negedge CpuClk) begin
      if (MemReq && !prev_mreq) begin
         g_addr.push_back(MemAddr);
         g_we.push_back(MemWe);
         g_wd.push_back(MemWdata);
      end
      prev_mreq <= MemReq;
   end

   // Memory responder: ack in the (ack_dly+1)-th cycle of MemReq.
   bit          auto_mem = 1'b1;
   int          ack_dly = -1;
   int          busy_cyc = 0;
   logic [31:0] mem_data = '0;

   always @(posedge CpuClk) begin
      #1;
      if (auto_mem) begin
         busy_cyc = MemReq ? busy_cyc + 1 : 0;
         MemAck   = (ack_dly >= 0) && MemReq && (busy_cyc == ack_dly + 1);
         MemRdata = mem_data;
      end
   end

   task automatic do_req(input bit d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int ncyc);
      logic ack;
      @(posedge CpuClk); #1;
      if (d) begin
         DReq = 1'b1; DWe = we; DAddr = addr; DWdata = wd;
      end else begin
         IReq = 1'b1; IAddr = addr;
      end
      ncyc = 0;
      ack  = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge CpuClk);
         ncyc++;
         ack = d ? DAck : IAck;
         if (ack) break;
      end
      chk(d ? "d_ack_seen" : "i_ack_seen", ack, 1'b1);
      @(posedge CpuClk); #1;
      if (d) DReq = 1'b0;
      else IReq = 1'b0;
   endtask

   task automatic pulse_rst();
      @(posedge CpuClk); #1;
      CpuRst = 1'b1;
      @(posedge CpuClk); #1;
      CpuRst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   int nc, nc2;
   int base;
   logic [31:0] exp_order[7];

   initial begin
      @(posedge CpuClk);
      chk_on = 1'b1;
      #1;
      @(posedge CpuClk); #1;
      CpuRst = 1'b0;
      @(negedge CpuClk);
      chk("rst_memreq", MemReq, 1'b0);
      chk("rst_irdata", IRdata, 32'h0);
      chk("rst_err", ErrTimeout, 1'b0);

      // I read, ack two cycles after MemReq rises.
      ack_dly = 2; mem_data = 32'hDEAD_BEEF;
      do_req(1'b0, 1'b0, 32'h0000_1000, 32'h0, nc);
      chk("i_lat", nc, 5);
      chk("i_rdata", IRdata, 32'hDEAD_BEEF);
      chk("i_addr", g_addr[g_addr.size()-1], 32'h0000_1000);
      chk("i_we", g_we[g_we.size()-1], 1'b0);

      // Minimum latency read.
      ack_dly = 0; mem_data = 32'h1111_2222;
      do_req(1'b0, 1'b0, 32'h0000_1004, 32'h0, nc);
      chk("i_minlat", nc, 3);

      // D write.
      ack_dly = 1; mem_data = 32'hCAFE_F00D;
      do_req(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, nc);
      chk("d_lat", nc, 4);
      chk("d_we", g_we[g_we.size()-1], 1'b1);
      chk("d_wdata", g_wd[g_wd.size()-1], 32'h1234_5678);
      chk("d_rdata", DRdata, 32'hCAFE_F00D);

      // Collisions from a fresh reset.
      pulse_rst();
      base = g_addr.size();
      ack_dly = 1;
      fork
         do_req(1'b1, 1'b0, 32'h2100, 32'h0, nc);
         do_req(1'b0, 1'b0, 32'h1100, 32'h0, nc2);
      join
      fork
         do_req(1'b1, 1'b0, 32'h2108, 32'h0, nc);
         do_req(1'b0, 1'b0, 32'h1108, 32'h0, nc2);
      join
      do_req(1'b1, 1'b0, 32'h2200, 32'h0, nc);
      fork
         do_req(1'b1, 1'b0, 32'h2300, 32'h0, nc);
         do_req(1'b0, 1'b0, 32'h1300, 32'h0, nc2);
      join
      exp_order[0] = 32'h2100; exp_order[1] = 32'h1100;
      exp_order[2] = 32'h2108; exp_order[3] = 32'h1108;
      exp_order[4] = 32'h2200;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order[5] = 32'h1300; exp_order[6] = 32'h2300;
`else
      exp_order[5] = 32'h2300; exp_order[6] = 32'h1300;
`endif
      chk("grant_cnt", g_addr.size() - base, 7);
      for (int i = 0; i < 7; i++) begin
         if (base + i < g_addr.size())
            chk($sformatf("grant_%0d", i), g_addr[base+i], exp_order[i]);
      end

      // Ack in the last allowed wait cycle: normal completion.
      ack_dly = 3; mem_data = 32'h5A5A_5A5A;
      do_req(1'b0, 1'b0, 32'h1500, 32'h0, nc);
      chk("edge_lat", nc, 6);
      chk("edge_rdata", IRdata, 32'h5A5A_5A5A);
      chk("edge_err", ErrTimeout, 1'b0);

      // No ack at all: timeout.
      ack_dly = -1; mem_data = 32'h9999_9999;
      do_req(1'b0, 1'b0, 32'h1400, 32'h0, nc);
      chk("tmo_lat", nc, 6);
      chk("tmo_rdata", IRdata, 32'h0);
      chk("tmo_err", ErrTimeout, 1'b1);
      ack_dly = 1; mem_data = 32'hABCD_0001;
      do_req(1'b1, 1'b0, 32'h2400, 32'h0, nc);
      chk("tmo_d_rdata", DRdata, 32'hABCD_0001);
      chk("tmo_err_held", ErrTimeout, 1'b1);
      pulse_rst();
      @(negedge CpuClk);
      chk("tmo_err_clr", ErrTimeout, 1'b0);

      // Reset in the second busy cycle, late ack afterwards.
      auto_mem = 1'b0;
      MemAck = 1'b0;
      @(posedge CpuClk); #1;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h2500;
      @(posedge CpuClk); #1;
      @(posedge CpuClk); #1;
      CpuRst = 1'b1;
      @(posedge CpuClk); #1;
      CpuRst = 1'b0; DReq = 1'b0;
      MemAck = 1'b1; MemRdata = 32'h7777_7777;
      @(negedge CpuClk);
      chk("mid_rst_memreq", MemReq, 1'b0);
      chk("mid_rst_addr", MemAddr, 32'h0);
      chk("mid_rst_dack", DAck, 1'b0);
      @(posedge CpuClk); #1;
      MemAck = 1'b0;
      @(negedge CpuClk);
      chk("late_ack_dack", DAck, 1'b0);
      chk("late_ack_drdata", DRdata, 32'h0);

      // Stray ack while idle.
      auto_mem = 1'b1;
      ack_dly = 0; mem_data = 32'h1357_2468;
      do_req(1'b0, 1'b0, 32'h1600, 32'h0, nc);
      auto_mem = 1'b0;
      MemAck = 1'b0;
      @(posedge CpuClk); #1;
      MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF;
      @(posedge CpuClk); #1;
      MemAck = 1'b0;
      @(negedge CpuClk);
      chk("idle_ack_memreq", MemReq, 1'b0);
      chk("idle_ack_iack", IAck, 1'b0);
      chk("idle_ack_irdata", IRdata, 32'h1357_2468);

      repeat (2) @(negedge CpuClk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
